exit_gate_controller: RTL and testbench

EXIT_GATE_CONTROLLER -- requirements
Module: exit_gate_controller

---
 rtl/exit_gate_controller.sv | 175 +++++++++++++++++
 tb/tb_exit_gate_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_gate_controller.sv
// Exit gate controller for a three-slot car park.
// Reads the entry time, charges the stay, takes payment, opens the gate.
module exit_gate_controller #(
  parameter int unsigned RATE        = 1,
  parameter int unsigned GATE_CYCLES = 5,
  parameter int unsigned PAY_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exit_req,
  input  logic [2:0] car_sel,
  input  logic [2:0] slot_occupied,
  input  logic [9:0] timer_count,
  input  logic [9:0] entry_time_in,
  input  logic       pay_valid,
  input  logic [9:0] pay_amount,
  output logic       rd_en,
  output logic [1:0] rd_sel,
  output logic [9:0] cost,
  output logic       cost_valid,
  output logic [9:0] change,
  output logic [2:0] clear_slot,
  output logic       gate_open,
  output logic       pay_reject,
  output logic       err
);

  localparam int TW = $clog2(PAY_TIMEOUT + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WAIT_PAY,
    OPEN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_exit_prev;
  logic [1:0]      r_sel;
  logic [9:0]      r_entry;
  logic [9:0]      r_cost;
  logic [9:0]      r_change;
  logic [2:0]      r_clear;
  logic            r_err;
  logic            r_rej;
  logic [TW-1:0]   r_tmo;
  logic [GW-1:0]   r_gcnt;

  logic            w_edge;
  logic            w_onehot;
  logic [1:0]      w_idx;
  logic            w_sel_ok;
  logic [9:0]      w_dur;
  logic [9:0]      w_dur_eff;
  logic [41:0]     w_prod;
  logic [9:0]      w_fee;
  logic            w_start;
  logic            w_bad;
  logic            w_acc;
  logic            w_rej;
  logic            w_tmo;

  assign w_edge = exit_req & ~r_exit_prev;

  // Decode the slot select; anything other than a single bit is invalid
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (car_sel)
      3'b001:  w_idx = 2'd0;
      3'b010:  w_idx = 2'd1;
      3'b100:  w_idx = 2'd2;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_sel_ok  = w_onehot & (|(car_sel & slot_occupied));
  assign w_dur     = timer_count - r_entry;
  assign w_dur_eff = (w_dur == 10'd0) ? 10'd1 : w_dur;
  assign w_prod    = {32'd0, w_dur_eff} * 42'(RATE);
  assign w_fee     = (w_prod > 42'd1023) ? 10'd1023 : w_prod[9:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and per-cycle event strobes
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_bad   = 1'b0;
    w_acc   = 1'b0;
    w_rej   = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge && !reset) begin
          if (w_sel_ok) begin
            w_start = 1'b1;
            w_next  = READ;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      READ: w_next = CALC;
      CALC: w_next = WAIT_PAY;
      WAIT_PAY: begin
        if (pay_valid && (pay_amount >= r_cost)) begin
          w_acc  = 1'b1;
          w_next = OPEN;
        end else begin
          w_rej = pay_valid;
          if (r_tmo == TW'(PAY_TIMEOUT - 1)) begin
            w_tmo  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      OPEN: begin
        if (r_gcnt == GW'(GATE_CYCLES - 1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: edge register, captured entry time, fee, counters, pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exit_prev <= 1'b0;
      r_sel       <= 2'd0;
      r_entry     <= 10'd0;
      r_cost      <= 10'd0;
      r_change    <= 10'd0;
      r_clear     <= 3'd0;
      r_err       <= 1'b0;
      r_rej       <= 1'b0;
      r_tmo       <= '0;
      r_gcnt      <= '0;
    end else begin
      r_exit_prev <= exit_req;
      r_err       <= w_bad | w_tmo;
      r_rej       <= w_rej;
      r_clear     <= w_acc ? (3'b001 << r_sel) : 3'd0;
      if (w_start) r_sel <= w_idx;
      if (r_state == READ) r_entry <= entry_time_in;
      if (r_state == CALC) begin
        r_cost <= w_fee;
        r_tmo  <= '0;
      end
      if (r_state == WAIT_PAY && !w_acc && !w_tmo) r_tmo <= r_tmo + 1'b1;
      if (w_acc) begin
        r_change <= pay_amount - r_cost;
        r_gcnt   <= '0;
      end
      if (r_state == OPEN) r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign rd_en      = w_start;
  assign rd_sel     = w_start ? w_idx : r_sel;
  assign cost       = r_cost;
  assign cost_valid = (r_state == WAIT_PAY);
  assign change     = r_change;
  assign clear_slot = r_clear;
  assign gate_open  = (r_state == OPEN);
  assign pay_reject = r_rej;
  assign err        = r_err;

endmodule

// File: tb/tb_exit_gate_controller.sv
// Bench for exit_gate_controller: directed and random exits
// against a fee/timeout reference model.
module tb_exit_gate_controller;

  localparam int PT = 30;
  localparam int GC = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       exit_req, exit_req4;
  logic [2:0] car_sel, slot_occupied;
  logic [9:0] timer_count, entry_time_in;
  logic       pay_valid, pay_valid4;
  logic [9:0] pay_amount, pay_amount4;

  logic       rd_en_a, cost_valid_a, gate_open_a, pay_reject_a, err_a;
  logic [1:0] rd_sel_a;
  logic [9:0] cost_a, change_a;
  logic [2:0] clear_slot_a;

  logic       rd_en_b, cost_valid_b, gate_open_b, pay_reject_b, err_b;
  logic [1:0] rd_sel_b;
  logic [9:0] cost_b, change_b;
  logic [2:0] clear_slot_b;

  int n_cmp  = 0;
  int n_fail = 0;

  exit_gate_controller dut_a (
    .clk(clk), .reset(reset), .exit_req(exit_req),
    .car_sel(car_sel), .slot_occupied(slot_occupied),
    .timer_count(timer_count), .entry_time_in(entry_time_in),
    .pay_valid(pay_valid), .pay_amount(pay_amount),
    .rd_en(rd_en_a), .rd_sel(rd_sel_a), .cost(cost_a),
    .cost_valid(cost_valid_a), .change(change_a),
    .clear_slot(clear_slot_a), .gate_open(gate_open_a),
    .pay_reject(pay_reject_a), .err(err_a)
  );

  exit_gate_controller #(.RATE(4)) dut_b (
    .clk(clk), .reset(reset), .exit_req(exit_req4),
    .car_sel(car_sel), .slot_occupied(slot_occupied),
    .timer_count(timer_count), .entry_time_in(entry_time_in),
    .pay_valid(pay_valid4), .pay_amount(pay_amount4),
    .rd_en(rd_en_b), .rd_sel(rd_sel_b), .cost(cost_b),
    .cost_valid(cost_valid_b), .change(change_b),
    .clear_slot(clear_slot_b), .gate_open(gate_open_b),
    .pay_reject(pay_reject_b), .err(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fee from the tariff rules: elapsed seconds modulo 1024,
  // at least one second, times rate, capped at 1023.
  function automatic int model_cost(input int ent, input int tmr,
                                    input int rate);
    int d;
    int c;
    d = (tmr - ent + 1024) % 1024;
    if (d == 0) d = 1;
    c = d * rate;
    if (c > 1023) c = 1023;
    return c;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One exit attempt on dut_a. pay_at/rej_at are WAIT_PAY cycle
  // indices (-1 = never); extra is the overpayment.
  task automatic run_txn(input logic [2:0] car, input logic [2:0] occ,
                         input int ent, input int tmr, input int pay_at,
                         input int rej_at, input int extra);
    bit ok;
    bit done;
    int idx;
    int c;
    int amt;
    int gcnt;
    ok  = (car == 3'b001 || car == 3'b010 || car == 3'b100) &&
          ((car & occ) != 3'd0);
    idx = car[1] ? 1 : (car[2] ? 2 : 0);
    amt = 0;
    exit_req  = 1'b0;
    pay_valid = 1'b0;
    step;
    car_sel       = car;
    slot_occupied = occ;
    timer_count   = tmr[9:0];
    entry_time_in = 10'($urandom);
    exit_req      = 1'b1;
    #1;
    chk("rd_en_edge", rd_en_a, ok);
    if (ok) chk("rd_sel", rd_sel_a, idx);
    step;
    if (!ok) begin
      chk("err_bad", err_a, 1);
      chk("rd_en_bad", rd_en_a, 0);
      chk("cv_bad", cost_valid_a, 0);
      exit_req = 1'b0;
      step;
      chk("err_clr", err_a, 0);
      chk("cv_idle", cost_valid_a, 0);
      return;
    end
    chk("rd_en_once", rd_en_a, 0);
    entry_time_in = ent[9:0];
    step;
    entry_time_in = 10'($urandom);
    exit_req = 1'b0;
    step;
    c = model_cost(ent, tmr, 1);
    chk("cost", cost_a, c);
    chk("cost_valid", cost_valid_a, 1);
    done = 1'b0;
    for (int i = 0; i < PT && !done; i++) begin
      pay_valid  = 1'b0;
      pay_amount = 10'($urandom);
      exit_req   = (i < PT - 1) ? 1'($urandom) : 1'b0;
      if (i == pay_at) begin
        amt = c + extra;
        if (amt > 1023) amt = 1023;
        pay_valid  = 1'b1;
        pay_amount = amt[9:0];
      end else if (i == rej_at) begin
        pay_valid  = 1'b1;
        pay_amount = 10'(c - 1);
      end
      step;
      pay_valid = 1'b0;
      if (i == pay_at) begin
        chk("clear_slot", clear_slot_a, car);
        chk("change", change_a, amt - c);
        chk("gate_on", gate_open_a, 1);
        chk("cv_paid", cost_valid_a, 0);
        done = 1'b1;
      end else if (i == rej_at) begin
        chk("pay_reject", pay_reject_a, 1);
        chk("cv_rej", cost_valid_a, 1);
        chk("clr_rej", clear_slot_a, 0);
      end else if (i == PT - 1) begin
        chk("err_tmo", err_a, 1);
        chk("cv_tmo", cost_valid_a, 0);
        chk("clr_tmo", clear_slot_a, 0);
        chk("gate_tmo", gate_open_a, 0);
      end else begin
        chk("cv_wait", cost_valid_a, 1);
        chk("clr_wait", clear_slot_a, 0);
        chk("rej_wait", pay_reject_a, 0);
      end
    end
    if (done) begin
      exit_req = 1'b0;
      gcnt = 1;
      for (int k = 0; k < 20 && gate_open_a; k++) begin
        step;
        exit_req = 1'b1;
        if (k == 0) chk("clr_pulse", clear_slot_a, 0);
        if (gate_open_a) gcnt++;
      end
      chk("gate_len", gcnt, GC);
      step;
      chk("no_retrig", rd_en_a, 0);
      chk("cv_after", cost_valid_a, 0);
      chk("cost_hold", cost_a, c);
      chk("chg_hold", change_a, amt - c);
    end else begin
      step;
      chk("err_once", err_a, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] car;
    logic [2:0] occ;
    int pay_at;
    int rej_at;
    reset         = 1'b1;
    exit_req      = 1'b1;
    exit_req4     = 1'b0;
    car_sel       = 3'b001;
    slot_occupied = 3'b111;
    timer_count   = 10'd0;
    entry_time_in = 10'd0;
    pay_valid     = 1'b0;
    pay_amount    = 10'd0;
    pay_valid4    = 1'b0;
    pay_amount4   = 10'd0;
    step;
    step;
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_sel", rd_sel_a, 0);
    chk("rst_cost", cost_a, 0);
    chk("rst_cv", cost_valid_a, 0);
    chk("rst_change", change_a, 0);
    chk("rst_clear", clear_slot_a, 0);
    chk("rst_gate", gate_open_a, 0);
    chk("rst_rej", pay_reject_a, 0);
    chk("rst_err", err_a, 0);
    exit_req = 1'b0;
    step;
    reset = 1'b0;
    step;

    run_txn(3'b001, 3'b001, 10, 25, 2, -1, 5);
    run_txn(3'b010, 3'b010, 1020, 4, 0, -1, 0);
    run_txn(3'b100, 3'b100, 300, 300, PT - 1, -1, 3);
    run_txn(3'b011, 3'b011, 5, 9, 0, -1, 0);
    run_txn(3'b010, 3'b101, 5, 9, 0, -1, 0);
    run_txn(3'b000, 3'b111, 5, 9, 0, -1, 0);
    run_txn(3'b001, 3'b001, 10, 25, -1, 3, 0);
    run_txn(3'b100, 3'b111, 0, 1023, 4, 1, 0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom % 5)
        0: car = 3'b001;
        1: car = 3'b010;
        2: car = 3'b100;
        default: car = 3'($urandom);
      endcase
      occ = ($urandom % 4 == 0) ? 3'($urandom) : 3'b111;
      pay_at = ($urandom % 4 == 0) ? -1 : int'($urandom % PT);
      rej_at = ($urandom % 2 == 0) ? -1 : int'($urandom % (PT - 1));
      run_txn(car, occ, int'($urandom % 1024), int'($urandom % 1024),
              pay_at, rej_at, int'($urandom % 50));
    end

    exit_req4     = 1'b0;
    step;
    car_sel       = 3'b001;
    slot_occupied = 3'b001;
    entry_time_in = 10'd0;
    timer_count   = 10'd400;
    exit_req4     = 1'b1;
    #1;
    chk("b_rd_en", rd_en_b, 1);
    step;
    step;
    step;
    chk("b_cost_sat", cost_b, model_cost(0, 400, 4));
    chk("b_cv", cost_valid_b, 1);
    pay_valid4  = 1'b1;
    pay_amount4 = 10'd1023;
    step;
    pay_valid4 = 1'b0;
    chk("b_gate", gate_open_b, 1);
    chk("b_clear", clear_slot_b, 3'b001);
    step;
    #2;
    reset = 1'b1;
    #1;
    chk("b_rst_gate", gate_open_b, 0);
    chk("b_rst_cost", cost_b, 0);
    chk("b_rst_clear", clear_slot_b, 0);
    chk("b_rst_cv", cost_valid_b, 0);
    chk("b_rst_rd_en", rd_en_b, 0);
    chk("b_rst_err", err_b, 0);
    chk("a_rst_cost", cost_a, 0);
    exit_req4 = 1'b0;
    step;
    reset = 1'b0;
    step;
    step;
    chk("b_post_gate", gate_open_b, 0);
    chk("b_post_clear", clear_slot_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
